pmux_skid_stage: RTL and testbench



---
 rtl/pmux_skid_stage.sv | 166 ++++++++++++++++
 tb/tb_pmux_skid_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pmux_skid_stage.sv
// ---------------------------------------------------------------------------
// pmux_skid_stage
//
// Priority select of one of NSRC data channels, registered into a 2-entry
// skid buffer (main register M drives the outputs, skid register S catches
// the beat accepted while the consumer stalls). in_ready is a register, so
// there is no combinational path from out_ready to in_ready, nor from in_*
// to out_*.
//
// Optional feature: define PMUX_STATS_EN to add per-source pop counters
// (16-bit, saturating) with a stat_clr input and a stat_cnt output.
//
// Parameters:
//   WIDTH  data width per channel (1..64)
//   NSRC   number of channels (2..8)
//   SRCW   width of the source index
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   din        packed channels, channel k = din[k*WIDTH +: WIDTH]
//   sel        priority request, sel[k] requests channel k+1, highest wins,
//              none set selects channel 0
//   in_valid   input beat present
//   in_ready   stage can accept (registered)
//   flush      discard all held and incoming beats
//   out_data   selected data (registered)
//   out_src    index of the channel that produced out_data
//   out_valid  out_data/out_src valid
//   out_ready  downstream accepts
//   stat_clr   (PMUX_STATS_EN) clear all counters
//   stat_cnt   (PMUX_STATS_EN) counter k at stat_cnt[k*16 +: 16]
// ---------------------------------------------------------------------------
module pmux_skid_stage #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 3,
   parameter int SRCW  = $clog2(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NSRC*WIDTH-1:0] din,
   input  logic [NSRC-2:0]       sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   output logic [WIDTH-1:0]      out_data,
   output logic [SRCW-1:0]       out_src,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef PMUX_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [NSRC*16-1:0]    stat_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,  // M and S invalid
      ONE   = 2'd1,  // M valid, S invalid
      FULL  = 2'd2   // M and S valid
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] s_data;
   logic [SRCW-1:0]  s_src;

   logic [SRCW-1:0]  sel_idx;
   logic [WIDTH-1:0] sel_data;
   logic             acc;
   logic             pop;

   assign acc = in_valid && in_ready;
   assign pop = out_valid && out_ready;

   // Priority select: later (higher) set bits overwrite earlier ones.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sel_idx = '0;
      for (int k = 0; k < NSRC - 1; k++) begin
         if (sel[k]) sel_idx = SRCW'(k + 1);
      end
      sel_data = din[int'(sel_idx) * WIDTH +: WIDTH];
   end

   // Occupancy FSM with registered outputs. in_ready tracks !S.valid and is
   // updated on the same edge S fills or drains, so FULL never accepts.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: s_data/s_src are payload only (qualified by state), so they are
   // deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         out_src   <= '0;
      end else if (flush) begin
         // out_data/out_src keep their last value; out_valid masks them.
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  out_data  <= sel_data;
                  out_src   <= sel_idx;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  out_data <= sel_data;
                  out_src  <= sel_idx;
               end else if (acc) begin
                  // Consumer stalled: park the new beat behind M.
                  s_data   <= sel_data;
                  s_src    <= sel_idx;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  out_data <= s_data;
                  out_src  <= s_src;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef PMUX_STATS_EN
   // Per-source pop counters; saturate rather than wrap. Not touched by flush.
   logic [15:0] cnt [NSRC];

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         for (int k = 0; k < NSRC; k++) cnt[k] <= '0;
      end else if (pop) begin
         for (int k = 0; k < NSRC; k++) begin
            if (out_src == SRCW'(k) && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
         end
      end
   end

   always_comb begin
      stat_cnt = '0;
      for (int k = 0; k < NSRC; k++) stat_cnt[k*16 +: 16] = cnt[k];
   end
`endif

endmodule

// File: tb/tb_pmux_skid_stage.sv
module tb_pmux_skid_stage;

   localparam int WIDTH = 32;
   localparam int NSRC  = 3;
   localparam int SRCW  = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NSRC*WIDTH-1:0] din;
   logic [NSRC-2:0]       sel;
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic [WIDTH-1:0]      out_data;
   logic [SRCW-1:0]       out_src;
   logic                  out_valid;
   logic                  out_ready;
`ifdef PMUX_STATS_EN
   logic                  stat_clr;
   logic [NSRC*16-1:0]    stat_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pmux_skid_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SRCW(SRCW)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef PMUX_STATS_EN
      ,
      .stat_clr  (stat_clr),
      .stat_cnt  (stat_cnt)
`endif
   );

   // Advance one edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      sel = '0; din = '0;
`ifdef PMUX_STATS_EN
      stat_clr = 1'b0;
`endif
      step(); step();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_priority();
      logic [1:0]  sels [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [31:0] expd [4] = '{32'h11, 32'h22, 32'h33, 32'h33};
      logic [1:0]  exps [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
      din = {32'h33, 32'h22, 32'h11};
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sel = sels[i];
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL prio_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== expd[i]) begin errors++; $display("FAIL prio_data[%0d] got=%h exp=%h", i, out_data, expd[i]); end
         checks++; if (out_src !== exps[i]) begin errors++; $display("FAIL prio_src[%0d] got=%0d exp=%0d", i, out_src, exps[i]); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      sel = 2'b00; out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = {32'h0, 32'h0, 32'h100 + 32'(i)};
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== 32'h100 + 32'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 32'h100 + 32'(i)); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      sel = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
      din = {64'h0, 32'h200};
      step();                                   // ONE: M=200
      out_ready = 1'b0; din = {64'h0, 32'h201};
      step();                                   // FULL: S=201
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
      checks++; if (out_data !== 32'h200) begin errors++; $display("FAIL bp_m_hold got=%h exp=200", out_data); end
      din = {64'h0, 32'h202};                   // offered but must not be taken
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h200) begin
            errors++; $display("FAIL bp_stall[%0d] got rdy=%b v=%b d=%h exp rdy=0 v=1 d=200", i, in_ready, out_valid, out_data);
         end
      end
      out_ready = 1'b1;
      step();                                   // pop 200, S->M
      checks++; if (out_data !== 32'h201 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got d=%h rdy=%b exp d=201 rdy=1", out_data, in_ready);
      end
      step();                                   // pop 201, accept 202
      checks++; if (out_data !== 32'h202 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_next got d=%h v=%b exp d=202 v=1", out_data, out_valid);
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      sel = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
      din = {64'h0, 32'h300}; step();
      din = {64'h0, 32'h301}; step();           // FULL
      flush = 1'b1; din = {64'h0, 32'h3FF}; step();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
      // Flush with an accepted beat in the same cycle: beat dropped.
      flush = 1'b1; din = {64'h0, 32'h3FE}; step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_drop got v=%b exp=0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got v=%b exp=0", out_valid); end
      in_valid = 1'b1; out_ready = 1'b1; din = {64'h0, 32'h310}; step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h310) begin
         errors++; $display("FAIL flush_recover got v=%b d=%h exp v=1 d=310", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_reset_midstream();
      sel = 2'b10; in_valid = 1'b1; out_ready = 1'b0;
      din = {32'h400, 64'h0}; step();
      din = {32'h401, 64'h0}; step();           // FULL, src 2
      checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL rstmid_pre_src got=%0d exp=2", out_src); end
      rst = 1'b1; step();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid got v=%b d=%h s=%0d rdy=%b exp v=0 d=0 s=0 rdy=1", out_valid, out_data, out_src, in_ready);
      end
   endtask

`ifdef PMUX_STATS_EN
   task automatic test_stats();
      rst = 1'b1; step(); rst = 1'b0;
      sel = 2'b01; in_valid = 1'b1; out_ready = 1'b1; din = {32'h0, 32'h55, 32'h0};
      for (int i = 0; i < 70001; i++) step();
      in_valid = 1'b0; step();                  // 70001 pops of src 1
      checks++; if (stat_cnt[31:16] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got=%h exp=ffff", stat_cnt[31:16]); end
      checks++; if (stat_cnt[15:0] !== 16'h0 || stat_cnt[47:32] !== 16'h0) begin
         errors++; $display("FAIL stats_other got c0=%h c2=%h exp 0 0", stat_cnt[15:0], stat_cnt[47:32]);
      end
      in_valid = 1'b1; step(); in_valid = 1'b0; // M valid, pop pending
      stat_clr = 1'b1; step(); stat_clr = 1'b0;
      checks++; if (stat_cnt[31:16] !== 16'h0) begin errors++; $display("FAIL stats_clr got=%h exp=0", stat_cnt[31:16]); end
   endtask
`endif

   initial begin
      test_reset();
      test_priority();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midstream();
`ifdef PMUX_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
